// File: rtl/gpu_pkg.sv
// Shared definitions for the frame sequencer: CSR word map, control/status
// bit positions and the tile sequencer state encoding.
package gpu_pkg;

   // CSR word addresses
   localparam logic [3:0] CSR_CONTROL     = 4'd0;
   localparam logic [3:0] CSR_STATUS      = 4'd1;
   localparam logic [3:0] CSR_PIXEL_BASE  = 4'd2;
   localparam logic [3:0] CSR_VOXEL_BUF   = 4'd3;
   localparam logic [3:0] CSR_VOXEL_COUNT = 4'd4;
   localparam logic [3:0] CSR_PALETTE_BUF = 4'd5;
   localparam logic [3:0] CSR_PALETTE_LEN = 4'd6;
   localparam logic [3:0] CSR_TILE_INDEX  = 4'd7;
   localparam logic [3:0] CSR_FRAME_COUNT = 4'd8;

   // CONTROL register bits
   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   // STATUS register bits
   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_DONE_BIT = 1;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_SETUP   = 3'd1,
      SEQ_LAUNCH  = 3'd2,
      SEQ_WAIT    = 3'd3,
      SEQ_ACK     = 3'd4,
      SEQ_ADVANCE = 3'd5,
      SEQ_FINISH  = 3'd6
   } seq_state_e;

endpackage

// File: rtl/gpu_frame_sequencer_if.sv
// Host CSR bus between the host and the frame sequencer.
//
// Handshake: s_write and s_read are single-cycle strobes qualified by
// s_address; there is no waitrequest, so every access completes in the cycle
// it is presented. s_readdata is registered and is valid on the cycle after
// the s_read strobe, holding its value until the next read.
interface gpu_frame_sequencer_if;
   logic [3:0]  s_address;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        s_read;
   logic [31:0] s_readdata;

   modport master (
      output s_address, s_write, s_writedata, s_read,
      input  s_readdata
   );

   modport slave (
      input  s_address, s_write, s_writedata, s_read,
      output s_readdata
   );
endinterface

// File: rtl/gpu_csr_slave.sv
// CSR register file for the frame sequencer: frame configuration, IRQ enable,
// DONE flag, frame counter and the registered read mux. Configuration writes
// are dropped while a frame is in flight so the controller sees stable values.
module gpu_csr_slave
   import gpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   gpu_frame_sequencer_if.slave bus,
   input  logic        busy_i,
   input  logic        finish_i,
   input  logic [31:0] tile_index_i,
   output logic        start_o,
   output logic        irq_en_o,
   output logic        done_o,
   output logic [31:0] pixel_base_o,
   output logic [31:0] voxel_buf_o,
   output logic [31:0] voxel_count_o,
   output logic [31:0] palette_buf_o,
   output logic [31:0] palette_len_o
);

   logic        irq_en_q, irq_en_d;
   logic        done_q, done_d;
   logic [31:0] pixel_base_q, pixel_base_d;
   logic [31:0] voxel_buf_q, voxel_buf_d;
   logic [31:0] voxel_count_q, voxel_count_d;
   logic [31:0] palette_buf_q, palette_buf_d;
   logic [31:0] palette_len_q, palette_len_d;
   logic [31:0] frame_count_q, frame_count_d;
   logic [31:0] readdata_q, readdata_d;
   logic [31:0] read_mux;
   logic        cfg_wr;

   // START is only honoured while idle; it is a strobe, never stored.
   assign start_o = bus.s_write && (bus.s_address == CSR_CONTROL)
                    && bus.s_writedata[CTRL_START_BIT] && !busy_i;
   assign cfg_wr  = bus.s_write && !busy_i;

   // Next-state for all CSR registers; DONE set by frame finish has priority.
   always_comb begin
      irq_en_d      = irq_en_q;
      done_d        = done_q;
      pixel_base_d  = pixel_base_q;
      voxel_buf_d   = voxel_buf_q;
      voxel_count_d = voxel_count_q;
      palette_buf_d = palette_buf_q;
      palette_len_d = palette_len_q;
      frame_count_d = frame_count_q;

      if (bus.s_write && (bus.s_address == CSR_CONTROL))
         irq_en_d = bus.s_writedata[CTRL_IRQ_EN_BIT];
      if (bus.s_write && (bus.s_address == CSR_STATUS) && bus.s_writedata[STAT_DONE_BIT])
         done_d = 1'b0;
      if (start_o)
         done_d = 1'b0;
      if (cfg_wr) begin
         case (bus.s_address)
            CSR_PIXEL_BASE:  pixel_base_d  = bus.s_writedata;
            CSR_VOXEL_BUF:   voxel_buf_d   = bus.s_writedata;
            CSR_VOXEL_COUNT: voxel_count_d = bus.s_writedata;
            CSR_PALETTE_BUF: palette_buf_d = bus.s_writedata;
            CSR_PALETTE_LEN: palette_len_d = bus.s_writedata;
            default: ;
         endcase
      end
      if (finish_i) begin
         done_d        = 1'b1;
         frame_count_d = frame_count_q + 32'd1;
      end
   end

   // Read mux; unmapped addresses return zero.
   always_comb begin
      read_mux = 32'd0;
      case (bus.s_address)
         CSR_CONTROL:     read_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
         CSR_STATUS: begin
            read_mux[STAT_BUSY_BIT] = busy_i;
            read_mux[STAT_DONE_BIT] = done_q;
         end
         CSR_PIXEL_BASE:  read_mux = pixel_base_q;
         CSR_VOXEL_BUF:   read_mux = voxel_buf_q;
         CSR_VOXEL_COUNT: read_mux = voxel_count_q;
         CSR_PALETTE_BUF: read_mux = palette_buf_q;
         CSR_PALETTE_LEN: read_mux = palette_len_q;
         CSR_TILE_INDEX:  read_mux = tile_index_i;
         CSR_FRAME_COUNT: read_mux = frame_count_q;
         default:         read_mux = 32'd0;
      endcase
      readdata_d = bus.s_read ? read_mux : readdata_q;
   end

   // CSR state registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq_en_q      <= 1'b0;
         done_q        <= 1'b0;
         pixel_base_q  <= 32'd0;
         voxel_buf_q   <= 32'd0;
         voxel_count_q <= 32'd0;
         palette_buf_q <= 32'd0;
         palette_len_q <= 32'd0;
         frame_count_q <= 32'd0;
         readdata_q    <= 32'd0;
      end else begin
         irq_en_q      <= irq_en_d;
         done_q        <= done_d;
         pixel_base_q  <= pixel_base_d;
         voxel_buf_q   <= voxel_buf_d;
         voxel_count_q <= voxel_count_d;
         palette_buf_q <= palette_buf_d;
         palette_len_q <= palette_len_d;
         frame_count_q <= frame_count_d;
         readdata_q    <= readdata_d;
      end
   end

   assign bus.s_readdata = readdata_q;
   assign irq_en_o       = irq_en_q;
   assign done_o         = done_q;
   assign pixel_base_o   = pixel_base_q;
   assign voxel_buf_o    = voxel_buf_q;
   assign voxel_count_o  = voxel_count_q;
   assign palette_buf_o  = palette_buf_q;
   assign palette_len_o  = palette_len_q;

endmodule

// File: rtl/gpu_frame_sequencer.sv
// Frame sequencer: walks the tile grid of a frame, launching gpu_controller
// once per tile and waiting for its tile-done interrupt before advancing.
// The pixel buffer address is an accumulator stepped by one tile per advance.
module gpu_frame_sequencer
   import gpu_pkg::*;
#(
   parameter int MY_ROWS    = 4,
   parameter int MY_COLS    = 4,
   parameter int TOTAL_ROWS = 240,
   parameter int TOTAL_COLS = 320,
   parameter int PIXEL_BITS = 16,
   parameter int TILE_BYTES = MY_ROWS * MY_COLS
) (
   input  logic                  clock,
   input  logic                  reset,
   gpu_frame_sequencer_if.slave  csr,
   output logic                  host_irq,
   output logic [PIXEL_BITS-1:0] start_row,
   output logic [PIXEL_BITS-1:0] start_col,
   output logic [31:0]           pixel_buffer,
   output logic [31:0]           voxel_buffer,
   output logic [31:0]           voxel_count,
   output logic [31:0]           palette_buffer,
   output logic [31:0]           palette_length,
   output logic                  do_render,
   output logic                  clear_interrupt,
   input  logic                  ctrl_irq,
   output seq_state_e            state_o
);

   localparam logic [PIXEL_BITS-1:0] ROW_STEP = PIXEL_BITS'(MY_ROWS);
   localparam logic [PIXEL_BITS-1:0] COL_STEP = PIXEL_BITS'(MY_COLS);
   localparam logic [PIXEL_BITS-1:0] COL_END  = PIXEL_BITS'(TOTAL_COLS);
   localparam logic [PIXEL_BITS-1:0] LAST_ROW = PIXEL_BITS'(TOTAL_ROWS - MY_ROWS);
   localparam logic [PIXEL_BITS-1:0] LAST_COL = PIXEL_BITS'(TOTAL_COLS - MY_COLS);
   localparam logic [31:0]           PIX_STEP = 32'(TILE_BYTES);

   seq_state_e            state_q, state_d;
   logic [PIXEL_BITS-1:0] tile_row_q, tile_row_d;
   logic [PIXEL_BITS-1:0] tile_col_q, tile_col_d;
   logic [31:0]           pix_addr_q, pix_addr_d;
   logic [31:0]           tile_index_q, tile_index_d;

   logic        busy;
   logic        start;
   logic        finish;
   logic        irq_en;
   logic        done;
   logic [31:0] pixel_base;
   logic        last_tile;

   assign busy      = (state_q != SEQ_IDLE);
   assign last_tile = (tile_row_q == LAST_ROW) && (tile_col_q == LAST_COL);

   gpu_csr_slave u_csr (
      .clock         (clock),
      .reset         (reset),
      .bus           (csr),
      .busy_i        (busy),
      .finish_i      (finish),
      .tile_index_i  (tile_index_q),
      .start_o       (start),
      .irq_en_o      (irq_en),
      .done_o        (done),
      .pixel_base_o  (pixel_base),
      .voxel_buf_o   (voxel_buffer),
      .voxel_count_o (voxel_count),
      .palette_buf_o (palette_buffer),
      .palette_len_o (palette_length)
   );

   // Tile sequencing: next state, tile counters and one-cycle strobes.
   always_comb begin
      state_d         = state_q;
      tile_row_d      = tile_row_q;
      tile_col_d      = tile_col_q;
      pix_addr_d      = pix_addr_q;
      tile_index_d    = tile_index_q;
      do_render       = 1'b0;
      clear_interrupt = 1'b0;
      finish          = 1'b0;

      case (state_q)
         SEQ_IDLE: begin
            if (start) begin
               state_d      = SEQ_SETUP;
               tile_row_d   = '0;
               tile_col_d   = '0;
               tile_index_d = 32'd0;
               pix_addr_d   = pixel_base;
            end
         end
         SEQ_SETUP: state_d = SEQ_LAUNCH;
         SEQ_LAUNCH: begin
            do_render = 1'b1;
            state_d   = SEQ_WAIT;
         end
         SEQ_WAIT: begin
            if (ctrl_irq) state_d = SEQ_ACK;
         end
         SEQ_ACK: begin
            clear_interrupt = 1'b1;
            state_d         = last_tile ? SEQ_FINISH : SEQ_ADVANCE;
         end
         SEQ_ADVANCE: begin
            // Wrap to the next tile row when the column reaches the frame edge.
            if ((tile_col_q + COL_STEP) == COL_END) begin
               tile_col_d = '0;
               tile_row_d = tile_row_q + ROW_STEP;
            end else begin
               tile_col_d = tile_col_q + COL_STEP;
            end
            pix_addr_d   = pix_addr_q + PIX_STEP;
            tile_index_d = tile_index_q + 32'd1;
            state_d      = SEQ_LAUNCH;
         end
         SEQ_FINISH: begin
            finish  = 1'b1;
            state_d = SEQ_IDLE;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // Sequencer state and tile counters; reset aborts any frame in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= SEQ_IDLE;
         tile_row_q   <= '0;
         tile_col_q   <= '0;
         pix_addr_q   <= 32'd0;
         tile_index_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         tile_row_q   <= tile_row_d;
         tile_col_q   <= tile_col_d;
         pix_addr_q   <= pix_addr_d;
         tile_index_q <= tile_index_d;
      end
   end

   assign host_irq     = done & irq_en;
   assign start_row    = tile_row_q;
   assign start_col    = tile_col_q;
   assign pixel_buffer = pix_addr_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// Bench for gpu_frame_sequencer on a 4x4 frame of 2x2 tiles, with a small
// gpu_controller model that answers each launch after 10 cycles.
module tb_gpu_frame_sequencer;
  import gpu_pkg::*;

  localparam int PB = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT ----------------
  gpu_frame_sequencer_if bus ();
  logic          host_irq, do_render, clear_interrupt, ctrl_irq;
  logic [PB-1:0] start_row, start_col;
  logic [31:0]   pixel_buffer, voxel_buffer, voxel_count, palette_buffer, palette_length;
  seq_state_e    state_o;

  gpu_frame_sequencer #(
    .MY_ROWS(2), .MY_COLS(2), .TOTAL_ROWS(4), .TOTAL_COLS(4), .PIXEL_BITS(PB)
  ) dut (
    .clock(clock), .reset(reset), .csr(bus), .host_irq(host_irq),
    .start_row(start_row), .start_col(start_col), .pixel_buffer(pixel_buffer),
    .voxel_buffer(voxel_buffer), .voxel_count(voxel_count),
    .palette_buffer(palette_buffer), .palette_length(palette_length),
    .do_render(do_render), .clear_interrupt(clear_interrupt),
    .ctrl_irq(ctrl_irq), .state_o(state_o)
  );

  // ---------------- controller model ----------------
  logic model_irq  = 1'b0;
  logic ctrl_force = 1'b0;
  logic ctrl_auto  = 1'b1;
  assign ctrl_irq = model_irq | ctrl_force;

  logic [63:0] launch_log [64];
  int launch_cnt = 0;
  int clr_cnt    = 0;
  int countdown  = 0;

  always @(negedge clock) begin
    if (reset) begin
      countdown = 0;
      model_irq = 1'b0;
    end else begin
      if (do_render) begin
        if (launch_cnt < 64) launch_log[launch_cnt] = {start_row, start_col, pixel_buffer};
        launch_cnt++;
        if (ctrl_auto) countdown = 10;
      end
      if (clear_interrupt) begin
        clr_cnt++;
        model_irq = 1'b0;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) model_irq = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    bus.s_address   = a;
    bus.s_writedata = d;
    bus.s_write     = 1'b1;
    @(negedge clock);
    bus.s_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    bus.s_address = a;
    bus.s_read    = 1'b1;
    @(negedge clock);
    bus.s_read    = 1'b0;
    d = bus.s_readdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic wait_launches(input int n, input int budget);
    int k = 0;
    while (launch_cnt < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("wait_launch", 64'(launch_cnt >= n), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (state_o != SEQ_IDLE && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("wait_idle", 64'(state_o == SEQ_IDLE), 64'd1);
  endtask

  // Row-major tile order; address steps by one 2x2 tile (4 bytes) per tile.
  task automatic expect_frame(input logic [31:0] base);
    for (int r = 0; r < 4; r += 2)
      for (int c = 0; c < 4; c += 2)
        exp_q.push_back({16'(r), 16'(c), base + 32'(((r / 2) * 2 + (c / 2)) * 4)});
  endtask

  task automatic check_frame(input int base);
    check("launch_count", 64'(launch_cnt - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      check($sformatf("tile%0d", i), launch_log[base + i], e);
    end
  endtask

  // ---------------- CSR vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;   // write data, or expected read data
  } csr_vec_t;

  csr_vec_t vecs [20];

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int clr_base;

    vecs[0]  = '{0, 4'h1, 32'h0};
    vecs[1]  = '{0, 4'h7, 32'h0};
    vecs[2]  = '{0, 4'h8, 32'h0};
    vecs[3]  = '{1, 4'h2, 32'h1000};
    vecs[4]  = '{1, 4'h3, 32'hA000};
    vecs[5]  = '{1, 4'h4, 32'h20};
    vecs[6]  = '{1, 4'h5, 32'hB000};
    vecs[7]  = '{1, 4'h6, 32'h10};
    vecs[8]  = '{1, 4'hF, 32'hDEAD};
    vecs[9]  = '{1, 4'h0, 32'h2};
    vecs[10] = '{0, 4'h2, 32'h1000};
    vecs[11] = '{0, 4'h3, 32'hA000};
    vecs[12] = '{0, 4'h4, 32'h20};
    vecs[13] = '{0, 4'h5, 32'hB000};
    vecs[14] = '{0, 4'h6, 32'h10};
    vecs[15] = '{0, 4'hF, 32'h0};
    vecs[16] = '{0, 4'h0, 32'h2};
    vecs[17] = '{0, 4'h1, 32'h0};
    vecs[18] = '{0, 4'h9, 32'h0};
    vecs[19] = '{0, 4'h7, 32'h0};

    bus.s_address   = 4'd0;
    bus.s_writedata = 32'd0;
    bus.s_write     = 1'b0;
    bus.s_read      = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state of outputs
    check("rst_state", 64'(state_o), 64'(SEQ_IDLE));
    check("rst_do_render", 64'(do_render), 64'd0);
    check("rst_clear_int", 64'(clear_interrupt), 64'd0);
    check("rst_host_irq", 64'(host_irq), 64'd0);
    check("rst_tile_out", {start_row, start_col, pixel_buffer}, 64'd0);

    // CSR table
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) csr_write(vecs[i].addr, vecs[i].data);
      else read_check($sformatf("vec%0d_a%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
    end
    check("cfg_out", {voxel_buffer, voxel_count}, {32'hA000, 32'h20});
    check("cfg_pal", {palette_buffer, palette_length}, {32'hB000, 32'h10});

    // Frame 1: IRQ_EN=1, with busy-time writes and a second START
    expect_frame(32'h1000);
    base = launch_cnt;
    clr_base = clr_cnt;
    csr_write(4'h0, 32'h3);
    read_check("busy_status", 4'h1, 32'h1);
    wait_launches(base + 1, 200);
    csr_write(4'h4, 32'h55);
    csr_write(4'h0, 32'h3);
    read_check("busy_wr_dropped", 4'h4, 32'h20);
    check("voxel_count_out", 64'(voxel_count), 64'h20);
    wait_launches(base + 3, 200);
    read_check("tile_index_t3", 4'h7, 32'd2);
    wait_idle(500);
    check_frame(base);
    check("clr_pulses", 64'(clr_cnt - clr_base), 64'd4);
    read_check("done_status", 4'h1, 32'h2);
    read_check("frame_count1", 4'h8, 32'd1);
    check("host_irq_set", 64'(host_irq), 64'd1);
    csr_write(4'h1, 32'h2);
    check("host_irq_clr", 64'(host_irq), 64'd0);
    read_check("status_clr", 4'h1, 32'h0);

    // Frame 2: IRQ_EN=0, DONE set but no host interrupt
    expect_frame(32'h1000);
    base = launch_cnt;
    csr_write(4'h0, 32'h1);
    wait_idle(500);
    check_frame(base);
    read_check("done_status2", 4'h1, 32'h2);
    check("host_irq_masked", 64'(host_irq), 64'd0);
    read_check("frame_count2", 4'h8, 32'd2);

    // Frame 3: START clears DONE, controller stalls on tile 2, then reset
    base = launch_cnt;
    clr_base = clr_cnt;
    csr_write(4'h0, 32'h1);
    read_check("start_clears_done", 4'h1, 32'h1);
    wait_launches(base + 1, 200);
    ctrl_auto = 1'b0;
    repeat (1000) @(negedge clock);
    check("stall_launches", 64'(launch_cnt - base), 64'd2);
    check("stall_state", 64'(state_o), 64'(SEQ_WAIT));
    check("stall_clr", 64'(clr_cnt - clr_base), 64'd1);
    read_check("stall_index", 4'h7, 32'd1);

    #2 reset = 1'b1;
    #1;
    check("arst_state", 64'(state_o), 64'(SEQ_IDLE));
    check("arst_do_render", 64'(do_render), 64'd0);
    check("arst_tile_out", {start_row, start_col, pixel_buffer}, 64'd0);
    check("arst_cfg", {voxel_buffer, voxel_count}, 64'd0);
    check("arst_pal", {palette_buffer, palette_length}, 64'd0);
    check("arst_host_irq", 64'(host_irq), 64'd0);
    base = launch_cnt;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    read_check("arst_tile_index", 4'h7, 32'd0);
    read_check("arst_frame_count", 4'h8, 32'd0);
    read_check("arst_pixel_base", 4'h2, 32'd0);
    read_check("arst_status", 4'h1, 32'd0);
    read_check("arst_control", 4'h0, 32'd0);
    check("arst_no_launch", 64'(launch_cnt - base), 64'd0);

    // ctrl_irq while idle is ignored
    clr_base = clr_cnt;
    ctrl_force = 1'b1;
    repeat (5) @(negedge clock);
    ctrl_force = 1'b0;
    check("idle_irq_no_clr", 64'(clr_cnt - clr_base), 64'd0);
    check("idle_irq_state", 64'(state_o), 64'(SEQ_IDLE));

    // Restart after reset begins again at tile (0,0)
    csr_write(4'h2, 32'h2000);
    ctrl_auto = 1'b1;
    expect_frame(32'h2000);
    base = launch_cnt;
    csr_write(4'h0, 32'h1);
    wait_idle(500);
    check_frame(base);
    read_check("restart_frames", 4'h8, 32'd1);
    read_check("restart_status", 4'h1, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
- Host-facing Avalon-MM slave CSR block that owns the per-frame render configuration.
- Sequences gpu_controller across every MY_ROWS x MY_COLS tile of a TOTAL_ROWS x TOTAL_COLS frame: drives start_row/start_col, do_render and a per-tile pixel_buffer address, then consumes its irq/clear_interrupt handshake.
- Raises one host interrupt per completed frame. Sits directly upstream of gpu_controller; camera registers are out of scope.

Parameters:
- MY_ROWS, 4, tile height in pixels; must divide TOTAL_ROWS.
- MY_COLS, 4, tile width in pixels; must divide TOTAL_COLS.
- TOTAL_ROWS, 240, frame height.
- TOTAL_COLS, 320, frame width.
- PIXEL_BITS, 16, width of start_row/start_col.
- TILE_BYTES, MY_ROWS*MY_COLS, pixel_buffer stride per tile (1 byte per pixel).

Ports:
- clock  in  1  clock
- reset  in  1  async active-high reset
- s_address  in  4  CSR word address
- s_write  in  1  CSR write strobe
- s_writedata  in  32  CSR write data
- s_read  in  1  CSR read strobe
- s_readdata  out  32  CSR read data, valid 1 cycle after s_read
- host_irq  out  1  frame-done interrupt to host
- start_row  out  PIXEL_BITS  current tile top row
- start_col  out  PIXEL_BITS  current tile left column
- pixel_buffer  out  32  current tile output base address
- voxel_buffer, voxel_count, palette_buffer, palette_length  out  32 each  frame configuration
- do_render  out  1  one-cycle tile launch pulse
- clear_interrupt  out  1  one-cycle acknowledge of ctrl_irq
- ctrl_irq  in  1  gpu_controller tile-done interrupt
- Reset/clock: reset reset, asynchronous, active-high; clock clock.

Behaviour:
- Reset: all registers, outputs and FSM state clear to 0 / IDLE. Async reset mid-frame aborts immediately; no further do_render is issued.
- CSR map (word address):
  - 0 CONTROL W: bit0 START (self-clearing), bit1 IRQ_EN (stored, readable).
  - 1 STATUS R: bit0 BUSY, bit1 DONE. Writing 1 to bit1 clears DONE.
  - 2 PIXEL_BASE, 3 VOXEL_BUF, 4 VOXEL_COUNT, 5 PALETTE_BUF, 6 PALETTE_LEN: R/W.
  - 7 TILE_INDEX R: current tile index.
  - 8 FRAME_COUNT R: completed frames, wraps at 2^32.
  - Other addresses: read 0, writes ignored.
- Writes to addresses 2-6 while BUSY are dropped, so configuration is stable for the whole frame.
- START while BUSY is ignored. START while idle clears DONE.
- host_irq = DONE & IRQ_EN, combinational from registers.
- FSM states:
  - IDLE: on START, go to SETUP. Clear tile_row, tile_col, TILE_INDEX; load pix_addr = PIXEL_BASE.
  - SETUP: one cycle so outputs are registered and stable; go to LAUNCH.
  - LAUNCH: do_render=1 for exactly one cycle; go to WAIT.
  - WAIT: hold until ctrl_irq=1; go to ACK.
  - ACK: clear_interrupt=1 for exactly one cycle. If last tile, go to FINISH; else go to ADVANCE.
  - ADVANCE:
    - tile_col += MY_COLS; if the result equals TOTAL_COLS, tile_col=0 and tile_row += MY_ROWS.
    - pix_addr += TILE_BYTES (accumulator, no multiplier); TILE_INDEX += 1.
    - Go to LAUNCH. This also gives the controller its one cycle to return to IDLE.
  - FINISH: set DONE, FRAME_COUNT += 1; go to IDLE.
- Last tile: tile_row == TOTAL_ROWS-MY_ROWS and tile_col == TOTAL_COLS-MY_COLS.
- BUSY = (state != IDLE).
- Output mapping: start_row=tile_row, start_col=tile_col, pixel_buffer=pix_addr; other controller config outputs are direct register copies.
- Minimum per-tile overhead: LAUNCH + ACK + ADVANCE = 3 cycles on top of controller time.
- ctrl_irq outside WAIT is ignored.
- Simultaneous CSR DONE-clear and FINISH in the same cycle: FINISH wins, DONE stays set.
- pix_addr arithmetic is 32-bit and wraps silently.
- Zero VOXEL_COUNT / PALETTE_LEN are still launched normally; the controller handles them.

Decomposition:
- gpu_pkg gets: CSR address localparams (CSR_CONTROL..CSR_FRAME_COUNT), CONTROL/STATUS bit-index constants, and the sequencer state enum.
- One natural sub-module: gpu_csr_slave (register file, read mux, BUSY write masking). The FSM and tile counters stay in gpu_frame_sequencer.

Test Plan:
- MY=2x2, TOTAL=4x4, PIXEL_BASE=0x1000; START; model controller responds with ctrl_irq 10 cycles after do_render. Expect 4 launches with (row,col,pixel_buffer) = (0,0,0x1000), (0,2,0x1004), (2,0,0x1008), (2,2,0x100C); DONE=1; FRAME_COUNT=1.
- IRQ_EN=1 and frame completes -> host_irq=1. Write STATUS=0x2 -> host_irq=0 next cycle. Repeat with IRQ_EN=0 -> host_irq stays 0 while DONE=1.
- Mid-frame write VOXEL_COUNT=0x55 and a second START -> register readback unchanged, no extra launch, tile sequence unaffected.
- Hold ctrl_irq low for 1000 cycles in WAIT -> no further do_render. Assert ctrl_irq while IDLE -> no clear_interrupt pulse.
- Async reset asserted during tile 2 WAIT -> BUSY=0, do_render=0, TILE_INDEX=0, all registers 0. New START restarts at tile (0,0).
- Read address 0xF -> s_readdata=0 one cycle later. Read TILE_INDEX during tile 3 -> 2.
